mem_access_unit: RTL

- Memory-access stage of the multi-cycle RV64 core; sits directly downstream of the control unit's s4 (memrw) state.
- Consumes the memu_valid/DMre/DMwe pulses and dreq_info from the control unit, plus the effective address (ALU result) and store data (rs2).
- Drives the data-bus request/response handshake, aligns store data and strobes, aligns and sign/zero-extends load data, and returns memu_finish.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage and its alignment helper.
// Used by both the build with MEMU_MISALIGN_CHECK_EN defined and the default build.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } memu_state_t;

   localparam logic [1:0] MSIZE_B = 2'd0;
   localparam logic [1:0] MSIZE_H = 2'd1;
   localparam logic [1:0] MSIZE_W = 2'd2;
   localparam logic [1:0] MSIZE_D = 2'd3;

   // dreq_info[2] selects zero-extension for loads
   localparam int INFO_UNSIGNED_BIT = 2;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0F;
   localparam logic [7:0] STRB_D = 8'hFF;

   function automatic logic [7:0] strobe_base(input logic [1:0] size);
      logic [7:0] s;
      case (size)
         MSIZE_B: s = STRB_B;
         MSIZE_H: s = STRB_H;
         MSIZE_W: s = STRB_W;
         default: s = STRB_D;
      endcase
      return s;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
      logic m;
      case (size)
         MSIZE_H: m = lo[0];
         MSIZE_W: m = |lo[1:0];
         MSIZE_D: m = |lo;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment: store strobe/data shift and load shift plus sign/zero extend.
// Used by both the build with MEMU_MISALIGN_CHECK_EN defined and the default build.
module mem_align
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      addr_lo,
   input  logic [2:0]      info,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [7:0]      strobe,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] load_ext
);

   logic [5:0]      shamt;
   logic [XLEN-1:0] raw;
   logic            uns;

   assign shamt    = {addr_lo, 3'b000};
   assign strobe   = strobe_base(info[1:0]) << addr_lo;
   assign wdata_sh = wdata << shamt;
   assign raw      = rdata >> shamt;
   assign uns      = info[INFO_UNSIGNED_BIT];

   always_comb begin
      load_ext = raw;
      case (info[1:0])
         MSIZE_B: load_ext = uns ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                 : {{(XLEN-8){raw[7]}}, raw[7:0]};
         MSIZE_H: load_ext = uns ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                 : {{(XLEN-16){raw[15]}}, raw[15:0]};
         MSIZE_W: load_ext = uns ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                 : {{(XLEN-32){raw[31]}}, raw[31:0]};
         default: load_ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: one bus transaction per start pulse, returns memu_finish one cycle after data_ok.
// Optional MEMU_MISALIGN_CHECK_EN adds the misalign output and skips the bus for unaligned starts.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memu_valid,
   input  logic              DMre,
   input  logic              DMwe,
   input  logic [2:0]        dreq_info,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              memu_finish,
`ifdef MEMU_MISALIGN_CHECK_EN
   output logic              misalign,
`endif
   output logic [XLEN-1:0]   load_data,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output logic [2:0]        dreq_size,
   output logic [7:0]        dreq_strobe,
   output logic [XLEN-1:0]   dreq_data,
   input  logic              dresp_data_ok,
   input  logic [XLEN-1:0]   dresp_data
);

   memu_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [2:0]        info_reg;
   logic              we_reg;
   logic [7:0]        strobe_reg;
   logic [XLEN-1:0]   data_reg;
   logic [XLEN-1:0]   load_data_reg;

   logic              is_mem;
   logic              mis_start;
   logic              latch_req;
   logic              capture_load;
   logic [2:0]        al_addr_lo;
   logic [2:0]        al_info;
   logic [7:0]        al_strobe;
   logic [XLEN-1:0]   al_wdata_sh;
   logic [XLEN-1:0]   al_load_ext;

   assign is_mem = DMre | DMwe;

`ifdef MEMU_MISALIGN_CHECK_EN
   logic misalign_reg;
   assign mis_start = is_misaligned(dreq_info[1:0], addr[2:0]);
`else
   assign mis_start = 1'b0;
`endif

   // In IDLE the aligner sees the incoming start; afterwards it sees the latched request
   assign al_addr_lo = (state_reg == IDLE) ? addr[2:0] : addr_reg[2:0];
   assign al_info    = (state_reg == IDLE) ? dreq_info : info_reg;

   mem_align #(.XLEN(XLEN)) u_align (
      .addr_lo  (al_addr_lo),
      .info     (al_info),
      .wdata    (wdata),
      .rdata    (dresp_data),
      .strobe   (al_strobe),
      .wdata_sh (al_wdata_sh),
      .load_ext (al_load_ext)
   );

   always_comb begin
      state_next   = state_reg;
      latch_req    = 1'b0;
      capture_load = 1'b0;
      case (state_reg)
         IDLE: begin
            if (memu_valid) begin
               if (is_mem && !mis_start) begin
                  latch_req  = 1'b1;
                  state_next = REQ;
               end else begin
                  state_next = DONE;
               end
            end
         end
         REQ: begin
            if (dresp_data_ok) begin
               capture_load = !we_reg;
               state_next   = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         info_reg      <= '0;
         we_reg        <= 1'b0;
         strobe_reg    <= '0;
         data_reg      <= '0;
         load_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (latch_req) begin
            addr_reg   <= addr;
            info_reg   <= dreq_info;
            we_reg     <= DMwe;
            strobe_reg <= DMwe ? al_strobe : 8'h00;
            data_reg   <= DMwe ? al_wdata_sh : '0;
         end
         if (capture_load) begin
            load_data_reg <= al_load_ext;
         end
      end
   end

`ifdef MEMU_MISALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_reg <= 1'b0;
      end else if (state_reg == IDLE && memu_valid) begin
         misalign_reg <= is_mem && mis_start;
      end
   end
   assign misalign = misalign_reg && (state_reg == DONE);
`endif

   assign dreq_valid  = (state_reg == REQ);
   assign memu_finish = (state_reg == DONE);
   assign dreq_addr   = addr_reg;
   assign dreq_size   = {1'b0, info_reg[1:0]};
   assign dreq_strobe = strobe_reg;
   assign dreq_data   = data_reg;
   assign load_data   = load_data_reg;

endmodule
